// File: rtl/piece_scanner_pkg.sv
// Chess board types plus scan-state and index helpers.
// Shared by piece_scanner, piece_match and the bench.
package piece_scanner_pkg;

  typedef enum logic {
    BLACK = 1'b0,
    WHITE = 1'b1
  } color_t;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  typedef struct packed {
    color_t color;
    piece_t piece;
  } fullpiece_t;

  typedef logic [6:0] piece_mask_t;

  localparam int NUM_PIECE_TYPES = 7;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } scan_state_t;

  // Square index is {row,col}; col_w sets the split point.
  function automatic int unsigned sq_idx(
    input int unsigned row,
    input int unsigned col,
    input int unsigned col_w
  );
    return (row << col_w) | col;
  endfunction

  function automatic int unsigned sq_row(
    input int unsigned idx,
    input int unsigned col_w
  );
    return idx >> col_w;
  endfunction

  function automatic int unsigned sq_col(
    input int unsigned idx,
    input int unsigned col_w
  );
    return idx & ((32'd1 << col_w) - 32'd1);
  endfunction

endpackage

// File: rtl/piece_scanner_match.sv
// Combinational square filter: piece mask plus colour test.
// Code 3'b111 indexes the padded zero bit and never hits.
module piece_match
  import piece_scanner_pkg::*;
(
  input  fullpiece_t  sq,
  input  piece_mask_t mask,
  input  color_t      color,
  input  logic        any_color,
  output logic        hit
);

  logic [7:0] mask8;
  logic       col_ok;

  always_comb begin
    mask8  = {1'b0, mask};
    col_ok = any_color
          || (sq.color == color)
          || (sq.piece == EMPTY);
    hit    = mask8[sq.piece] && col_ok;
  end

endmodule

// File: rtl/piece_scanner.sv
// Board register store with an index-order filtered scanner.
// SCAN_COUNT_EN adds a match_count port counting accepted matches.
module piece_scanner
  import piece_scanner_pkg::*;
#(
  parameter  int ROW_W = 3,
  parameter  int COL_W = 3,
  localparam int IDX_W = ROW_W + COL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [3:0]       wr_piece,
  input  logic             start,
  input  logic             match_color,
  input  logic             any_color,
  input  logic [6:0]       piece_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [3:0]       out_piece,
`ifdef SCAN_COUNT_EN
  output logic [IDX_W:0]   match_count,
`endif
  output logic             busy,
  output logic             done
);

  localparam int NSQ = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSQ - 1);

  fullpiece_t       board [NSQ];
  scan_state_t      state, nxt;
  logic [IDX_W-1:0] ptr;
  color_t           f_color;
  logic             f_any;
  piece_mask_t      f_mask;
  fullpiece_t       cur;
  logic             hit;
  logic             accept;
  logic             at_last;

  assign cur     = board[ptr];
  assign at_last = (ptr == LAST);
  assign accept  = (state == HOLD) && out_valid && out_ready;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  piece_match u_match (
    .sq        (cur),
    .mask      (f_mask),
    .color     (f_color),
    .any_color (f_any),
    .hit       (hit)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = SCAN;
      SCAN: begin
        if (hit)          nxt = HOLD;
        else if (at_last) nxt = DONE;
      end
      HOLD: if (accept) nxt = at_last ? DONE : SCAN;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Registers, not RAM: reset clears every square in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSQ; i++) board[i] <= '0;
    end else if (wr_en) begin
      board[wr_idx] <= fullpiece_t'(wr_piece);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_piece <= '0;
      f_color   <= BLACK;
      f_any     <= 1'b0;
      f_mask    <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          ptr     <= '0;
          f_color <= color_t'(match_color);
          f_any   <= any_color;
          f_mask  <= piece_mask_t'(piece_mask);
        end
        SCAN: begin
          if (hit) begin
            out_valid <= 1'b1;
            out_idx   <= ptr;
            out_piece <= cur;
          end else if (!at_last) begin
            ptr <= ptr + 1'b1;
          end
        end
        HOLD: if (accept) begin
          out_valid <= 1'b0;
          if (!at_last) ptr <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SCAN_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst)                         match_count <= '0;
    else if (state == IDLE && start) match_count <= '0;
    else if (accept)                 match_count <= match_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_piece_scanner.sv
// Directed bench for piece_scanner with an expected-output queue.
module tb_piece_scanner;
  import piece_scanner_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [5:0] wr_idx = '0;
  logic [3:0] wr_piece = '0;
  logic       start = 1'b0;
  logic       match_color = 1'b0;
  logic       any_color = 1'b0;
  logic [6:0] piece_mask = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_idx;
  logic [3:0] out_piece;
  logic       busy;
  logic       done;
`ifdef SCAN_COUNT_EN
  logic [6:0] match_count;
`endif

  piece_scanner #(.ROW_W(3), .COL_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_piece    (wr_piece),
    .start       (start),
    .match_color (match_color),
    .any_color   (any_color),
    .piece_mask  (piece_mask),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_piece   (out_piece),
`ifdef SCAN_COUNT_EN
    .match_count (match_count),
`endif
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [5:0] idx;
    logic [3:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   s = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int idx, input logic [3:0] pc);
    exp_t e;
    e.idx = 6'(idx);
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic wr(input int idx, input logic [3:0] pc);
    wr_en    = 1'b1;
    wr_idx   = 6'(idx);
    wr_piece = pc;
    step(1);
    wr_en    = 1'b0;
  endtask

  task automatic go(input logic col, input logic any,
                    input logic [6:0] mask);
    match_color = col;
    any_color   = any;
    piece_mask  = mask;
    start       = 1'b1;
    step(1);
    s     = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int n = 0;
    while (!done && n < 400) begin
      step(1);
      n++;
    end
    chk({tag, "_done_lat"}, 32'(cyc - s), 32'(lat));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic done_pulse(input string tag);
    step(1);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
  endtask

  // Compare every accepted output against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_idx", {26'b0, out_idx}, {26'b0, e.idx});
        chk("out_piece", {28'b0, out_piece}, {28'b0, e.pc});
      end
    end
  end

  initial begin
    int dc;
    step(2);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_idx", {26'b0, out_idx}, 0);
    chk("rst_piece", {28'b0, out_piece}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    step(1);

    // 1: empty board, everything matches
    for (int i = 0; i < 64; i++) push(i, 4'h0);
    go(1'b0, 1'b1, 7'h7F);
    wait_done("t1", 128);
    done_pulse("t1");

    // 2: two kings, white king only
    wr(sq_idx(0, 4, 3), 4'hE);
    wr(sq_idx(7, 4, 3), 4'h6);
    push(4, 4'hE);
    go(1'b1, 1'b0, 7'h40);
    wait_done("t2", 65);
    done_pulse("t2");

    // 3: back-pressure and write to held square
    out_ready = 1'b0;
    push(4, 4'hE);
    go(1'b1, 1'b0, 7'h40);
    dc = 0;
    while (!out_valid && dc < 100) begin
      step(1);
      dc++;
    end
    chk("t3_valid_lat", 32'(cyc - s), 32'd5);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        wr(4, 4'h9);
      end else begin
        step(1);
      end
      chk("t3_hold_valid", {31'b0, out_valid}, 1);
      chk("t3_hold_idx", {26'b0, out_idx}, 4);
      chk("t3_hold_piece", {28'b0, out_piece}, 32'hE);
    end
    out_ready = 1'b1;
    wait_done("t3", 75);
    done_pulse("t3");
    wr(4, 4'hE);

    // 4: writes ahead of and behind the pointer
    push(40, 4'h9);
    go(1'b1, 1'b0, 7'h02);
    while (cyc - s < 20) step(1);
    wr(40, 4'h9);
    wr(10, 4'h9);
    wait_done("t4", 65);
    done_pulse("t4");

    // 5a: start while busy is ignored
    go(1'b0, 1'b0, 7'h00);
    while (cyc - s < 10) step(1);
    any_color  = 1'b1;
    piece_mask = 7'h7F;
    start      = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("t5_busy", 64);
    done_pulse("t5_busy");

    // 5b: reset while holding a match at square 30
    wr(30, 4'hD);
    out_ready = 1'b0;
    go(1'b1, 1'b0, 7'h20);
    dc = 0;
    while (!out_valid && dc < 100) begin
      step(1);
      dc++;
    end
    chk("t5_hold_idx", {26'b0, out_idx}, 30);
    rst = 1'b1;
    step(1);
    chk("t5_rst_busy", {31'b0, busy}, 0);
    chk("t5_rst_valid", {31'b0, out_valid}, 0);
    chk("t5_rst_done", {31'b0, done}, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    dc = 0;
    repeat (70) begin
      step(1);
      if (done || busy) dc++;
    end
    chk("t5_no_done", 32'(dc), 0);
    for (int i = 0; i < 64; i++) push(i, 4'h0);
    go(1'b0, 1'b1, 7'h7F);
    wait_done("t5_clear", 128);
    done_pulse("t5_clear");

`ifdef SCAN_COUNT_EN
    // 6: count sixteen pawns of both colours
    for (int i = 8; i < 16; i++) wr(i, 4'h9);
    for (int i = 48; i < 56; i++) wr(i, 4'h1);
    for (int i = 8; i < 16; i++) push(i, 4'h9);
    for (int i = 48; i < 56; i++) push(i, 4'h1);
    go(1'b0, 1'b1, 7'h02);
    wait_done("t6", 80);
    chk("t6_count_done", {25'b0, match_count}, 16);
    step(5);
    chk("t6_count_held", {25'b0, match_count}, 16);
    go(1'b0, 1'b0, 7'h00);
    chk("t6_count_clr", {25'b0, match_count}, 0);
    wait_done("t6_empty", 64);
    done_pulse("t6_empty");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
